// File: rtl/data_memory_bank.sv
// Byte-lane writable word memory behind a valid/ready request port, returning one
// in-order response per request through a credit-limited buffer. Optional DMEM_ADDR_CHECK_EN.
module data_memory_bank #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH_WORDS = 1024,
   parameter int READ_LAT    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int BUF_D = READ_LAT + 1;
   localparam int PTR_W = $clog2(BUF_D);
   localparam int CNT_W = 3;
   localparam int LAST  = READ_LAT - 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   logic [ADDR_WIDTH-1:0] word_full;
   logic [IDX_W-1:0]      req_idx;
   logic                  req_err;
   logic                  addr_unused;
   logic                  accept;

   assign word_full   = req_addr >> OFF_W;
   assign req_idx     = word_full[IDX_W-1:0];
   assign addr_unused = ^{req_addr, word_full};
   assign accept      = req_valid & req_ready;

`ifdef DMEM_ADDR_CHECK_EN
   assign req_err = ((req_addr & ADDR_WIDTH'(BE_W - 1)) != '0) ||
                    ({1'b0, word_full} >= (ADDR_WIDTH + 1)'(DEPTH_WORDS));
`else
   assign req_err = 1'b0;
`endif

   logic             pipe_vld [READ_LAT];
   logic             pipe_we  [READ_LAT];
   logic             pipe_err [READ_LAT];
   logic [IDX_W-1:0] pipe_idx [READ_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < READ_LAT; i++) pipe_vld[i] <= 1'b0;
      end else begin
         pipe_vld[0] <= accept;
         for (int i = 1; i < READ_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_we[0]  <= req_we;
      pipe_err[0] <= req_err;
      pipe_idx[0] <= req_idx;
      for (int i = 1; i < READ_LAT; i++) begin
         pipe_we[i]  <= pipe_we[i-1];
         pipe_err[i] <= pipe_err[i-1];
         pipe_idx[i] <= pipe_idx[i-1];
      end
   end

   // Writes land at acceptance; reads sample READ_LAT edges later, so a later read sees them.
   always_ff @(posedge clk) begin
      if (accept && req_we && !req_err) begin
         for (int b = 0; b < BE_W; b++) begin
            if (req_be[b]) mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

   logic [DATA_WIDTH-1:0] rbuf_data [BUF_D];
   logic                  rbuf_err  [BUF_D];
   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic [CNT_W-1:0]      count, inflight, occ;
   logic                  push, pop;
   logic [DATA_WIDTH-1:0] push_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_D - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push      = pipe_vld[LAST];
   assign push_data = (pipe_we[LAST] || pipe_err[LAST]) ? '0 : mem[pipe_idx[LAST]];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            rbuf_data[wr_ptr] <= push_data;
            rbuf_err[wr_ptr]  <= pipe_err[LAST];
            wr_ptr            <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LAT; i++) inflight = inflight + CNT_W'(pipe_vld[i]);
   end

   assign occ        = count + inflight;
   assign resp_valid = !rst && (count != '0);
   assign pop        = resp_valid & resp_ready;
   // A slot freed by this cycle's pop counts as a credit, otherwise streaming stalls every other cycle.
   assign req_ready  = !rst && ((occ - CNT_W'(pop)) < CNT_W'(BUF_D));
   assign resp_rdata = resp_valid ? rbuf_data[rd_ptr] : '0;
   assign resp_err   = resp_valid ? rbuf_err[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench for data_memory_bank (READ_LAT=2) with a queue-based reference model
// checked every cycle, plus literal expectations on selected responses.
module tb_data_memory_bank;

   localparam int RL  = 2;
   localparam int CAP = RL + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  req_be = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [15:0] resp_rdata;
   logic        resp_err;

   data_memory_bank #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH_WORDS(1024), .READ_LAT(RL)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          acc;
      logic [15:0] data;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mmem [0:1023];
   int          edge_n = 0;
   int          n_acc = 0;
   logic [15:0] log_data[$];
   logic        log_err[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic addr_err(input logic [15:0] a);
`ifdef DMEM_ADDR_CHECK_EN
      return a[0] || ((a >> 1) >= 16'd1024);
`else
      return 1'b0;
`endif
   endfunction

   initial for (int i = 0; i < 1024; i++) mmem[i] = '0;

   // Reference model: each accepted request becomes visible RL edges later, leaves on pop.
   always @(posedge clk) begin
      exp_t e;
      int   idx;
      logic mv, mpop, mready;
      mv     = !rst && exp_q.size() > 0 && (exp_q[0].acc + RL <= edge_n);
      mpop   = mv && resp_ready;
      mready = !rst && ((exp_q.size() - (mpop ? 1 : 0)) < CAP);
      if (resp_valid && resp_ready) begin
         log_data.push_back(resp_rdata);
         log_err.push_back(resp_err);
      end
      if (req_valid && req_ready) n_acc++;
      edge_n++;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (mpop) void'(exp_q.pop_front());
         if (req_valid && mready) begin
            idx   = int'(req_addr >> 1) % 1024;
            e.acc = edge_n;
            e.err = addr_err(req_addr);
            if (req_we) begin
               e.data = '0;
               if (!e.err) begin
                  if (req_be[0]) mmem[idx][7:0]  = req_wdata[7:0];
                  if (req_be[1]) mmem[idx][15:8] = req_wdata[15:8];
               end
            end else begin
               e.data = e.err ? 16'h0 : mmem[idx];
            end
            exp_q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      logic ev, er;
      ev = !rst && exp_q.size() > 0 && (exp_q[0].acc + RL <= edge_n);
      er = !rst && ((exp_q.size() - ((ev && resp_ready) ? 1 : 0)) < CAP);
      chk("resp_valid", resp_valid, ev);
      chk("req_ready", req_ready, er);
      if (ev && resp_valid) begin
         chk("resp_rdata", resp_rdata, exp_q[0].data);
         chk("resp_err", resp_err, exp_q[0].err);
      end
      if (rst) begin
         chk("rst_rdata", resp_rdata, 16'h0);
         chk("rst_err", resp_err, 1'b0);
      end
   end

   task automatic send(input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] be);
      int t;
      req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL send_timeout: req_ready stayed 0 for addr %h", a);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      req_valid = 1'b0;
      t = 0;
      while (exp_q.size() > 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (exp_q.size() > 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] last_data(input int back);
      return log_data[log_data.size() - 1 - back];
   endfunction

   function automatic logic last_err(input int back);
      return log_err[log_err.size() - 1 - back];
   endfunction

   initial begin
      int base, lbase;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("ready_in_rst", req_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1'b1);
      @(posedge clk); #1;

      send(1'b1, 16'h0010, 16'hBEEF, 2'b11);
      send(1'b0, 16'h0010, 16'h0000, 2'b00);
      drain();
      chk("wr_resp_rdata", last_data(1), 16'h0000);
      chk("rd_beef", last_data(0), 16'hBEEF);
      chk("rd_beef_err", last_err(0), 1'b0);

      send(1'b1, 16'h0020, 16'hFFFF, 2'b11);
      send(1'b1, 16'h0020, 16'h1234, 2'b01);
      send(1'b0, 16'h0020, 16'h0000, 2'b00);
      drain();
      chk("rd_ff34", last_data(0), 16'hFF34);

      send(1'b1, 16'h0000, 16'hA5C3, 2'b11);
      send(1'b0, 16'h0000, 16'h0000, 2'b00);
      drain();
      chk("rd_a5c3", last_data(0), 16'hA5C3);

      // Backpressure: only CAP reads get in while the consumer stalls.
      resp_ready = 1'b0;
      req_we = 1'b0;
      req_valid = 1'b1;
      base = n_acc;
      for (int i = 0; i < 8; i++) begin
         req_addr = (i % 2 == 1) ? 16'h0020 : 16'h0010;
         @(posedge clk); #1;
      end
      chk("stall_accepts", 16'(n_acc - base), 16'd3);
      @(negedge clk);
      chk("stall_ready", req_ready, 1'b0);
      @(posedge clk); #1;
      lbase = log_data.size();
      resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_addr = (i % 2 == 1) ? 16'h0020 : 16'h0010;
         @(posedge clk); #1;
      end
      base = n_acc;
      for (int i = 0; i < 10; i++) begin
         req_addr = (i % 2 == 1) ? 16'h0020 : 16'h0010;
         @(posedge clk); #1;
      end
      chk("stream_accepts", 16'(n_acc - base), 16'd10);
      chk("stall_pop0", log_data[lbase], 16'hBEEF);
      chk("stall_pop1", log_data[lbase + 1], 16'hFF34);
      chk("stall_pop2", log_data[lbase + 2], 16'hBEEF);
      drain();

      send(1'b1, 16'h0011, 16'h0000, 2'b11);
      send(1'b0, 16'h0010, 16'h0000, 2'b00);
      drain();
`ifdef DMEM_ADDR_CHECK_EN
      chk("misalign_wr_err", last_err(1), 1'b1);
      chk("misalign_mem_kept", last_data(0), 16'hBEEF);
`else
      chk("misalign_wr_err", last_err(1), 1'b0);
      chk("misalign_wr_hits_word8", last_data(0), 16'h0000);
`endif

      send(1'b0, 16'h0800, 16'h0000, 2'b00);
      drain();
`ifdef DMEM_ADDR_CHECK_EN
      chk("range_err", last_err(0), 1'b1);
      chk("range_rdata", last_data(0), 16'h0000);
`else
      chk("wrap_err", last_err(0), 1'b0);
      chk("wrap_rdata", last_data(0), 16'hA5C3);
`endif

      // Reset with two reads in flight: neither may ever respond.
      send(1'b0, 16'h0010, 16'h0000, 2'b00);
      send(1'b0, 16'h0020, 16'h0000, 2'b00);
      rst = 1'b1;
      lbase = log_data.size();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", resp_valid, 1'b0);
      chk("post_rst_ready", req_ready, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_no_resp", 16'(log_data.size() - lbase), 16'd0);

      send(1'b0, 16'h0020, 16'h0000, 2'b00);
      drain();
      chk("post_rst_read", last_data(0), 16'hFF34);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_memory_bank.md
DATA_MEMORY_BANK -- requirements
Module: data_memory_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter ADDR_WIDTH, default 16: request byte-address width.
REQ-003 Parameter DEPTH_WORDS, default 1024: number of storage words; SHALL be a power of two.
REQ-004 Parameter READ_LAT, default 1: array read latency in cycles; legal values 1 or 2.
REQ-005 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block accepts a request this cycle.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_WIDTH  byte address.
REQ-011 req_wdata  in  DATA_WIDTH  write data.
REQ-012 req_be  in  DATA_WIDTH/8  byte-lane write strobes; ignored for reads.
REQ-013 resp_valid  out  1  response present.
REQ-014 resp_ready  in  1  consumer accepts the response.
REQ-015 resp_rdata  out  DATA_WIDTH  read data; 0 for write responses.
REQ-016 resp_err  out  1  request was in error.

Function
REQ-017 A request SHALL be accepted when req_valid and req_ready are both 1 on a rising edge.
REQ-018 Word index SHALL be req_addr shifted right by log2(DATA_WIDTH/8).
REQ-019 An accepted write SHALL update only the byte lanes whose req_be bit is 1, in the acceptance cycle.
REQ-020 An accepted read SHALL sample the array READ_LAT cycles after acceptance, and its data SHALL be pushed into the response buffer on that cycle.
REQ-021 Every accepted request (read or write) SHALL produce exactly one response; responses SHALL be returned in acceptance order.
REQ-022 Write responses SHALL take the same READ_LAT-cycle path as reads, with resp_rdata = 0.
REQ-023 The response buffer SHALL hold READ_LAT+1 entries and present its head on resp_rdata/resp_err whenever resp_valid=1.
REQ-024 A response SHALL leave the buffer only on resp_valid & resp_ready; while resp_ready=0, the head SHALL remain stable.
REQ-025 req_ready SHALL be 1 iff buffered responses plus in-flight requests are fewer than READ_LAT+1 (credit rule); the buffer SHALL never overflow.
REQ-026 A pop and an arrival in the same cycle SHALL leave the occupancy unchanged.
REQ-027 With resp_ready held at 1, the block SHALL sustain one request per cycle.
REQ-028 Back-to-back write then read of the same word SHALL return the newly written data (write-before-read ordering).
REQ-029 A read and a write are never concurrent (one request per cycle), so no same-cycle collision case exists.

Reset
REQ-030 While rst=1: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, the pipeline and response buffer SHALL be emptied, and no writes SHALL occur.
REQ-031 Requests in flight when rst is asserted SHALL be discarded without producing a response.
REQ-032 Array contents SHALL NOT be reset.
REQ-033 req_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-034 Macro DMEM_ADDR_CHECK_EN, when defined: a request with nonzero byte-offset bits (misaligned) or with word index >= DEPTH_WORDS SHALL set resp_err=1, SHALL NOT write, and SHALL return resp_rdata=0.
REQ-035 DMEM_ADDR_CHECK_EN not defined: offset bits SHALL be ignored, the word index SHALL wrap modulo DEPTH_WORDS, and resp_err SHALL be tied to 0.

Verification
REQ-036 Reset, then write 0xBEEF at addr 0x0010 with be=11, then read 0x0010 -> read response shows rdata=0xBEEF, err=0.
REQ-037 Write 0xFFFF, then write 0x1234 with be=01 to 0x0020, then read 0x0020 -> rdata=0xFF34.
REQ-038 READ_LAT=2, resp_ready=0, issue reads continuously -> exactly 3 accepted, then req_ready=0; raise resp_ready -> 3 responses in order, then streaming resumes at 1 request per cycle.
REQ-039 With DMEM_ADDR_CHECK_EN defined, write to 0x0011 -> err=1 and memory unchanged; with DEPTH_WORDS=1024, read at 0x0800 -> err=1. With the macro undefined, read at 0x0800 -> returns word 0 contents, err=0.
REQ-040 Assert rst with 2 reads in flight -> no response appears after reset; resp_valid=0 and req_ready=1 one cycle after rst falls.
